// File: rtl/hedios_pkg.sv
// Shared types and widths for the HEDIOS serial TX path.
package hedios_pkg;

    localparam int HEDIOS_CMD_W  = 8;
    localparam int HEDIOS_DATA_W = 32;

    typedef struct packed {
        logic [HEDIOS_CMD_W-1:0]  cmd;
        logic [HEDIOS_DATA_W-1:0] data;
    } hedios_packet_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_PUSH   = 2'd1,
        ARB_SETTLE = 2'd2
    } hedios_arb_state_t;

endpackage

// File: rtl/hedios_rr_picker.sv
// Combinational round-robin picker: first set mask bit after ptr, wrapping N-1 -> 0.
module hedios_rr_picker
    import hedios_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] index
);

    int idx;

    // Scan offsets 1..N so the pointer itself is considered last.
    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && mask[idx[ID_W-1:0]]) begin
                found = 1'b1;
                index = idx[ID_W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/hedios_tx_arbiter.sv
// Two-class round-robin arbiter with an HP burst limit feeding the single HEDIOS TX queue.
module hedios_tx_arbiter
    import hedios_pkg::*;
#(
    parameter int                NUM_REQ        = 4,
    parameter logic [NUM_REQ-1:0] HIGH_PRIO_MASK = 4'b0001,
    parameter int                MAX_HP_BURST   = 4,
    localparam int               ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][HEDIOS_CMD_W-1:0]    req_command,
    input  logic [NUM_REQ-1:0][HEDIOS_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic                                    tx_full,
    input  logic                                    tx_empty,
    output logic                                    tx_push_packet,
    output logic [HEDIOS_CMD_W-1:0]                 tx_command,
    output logic [HEDIOS_DATA_W-1:0]                tx_data,
    output logic [ID_W-1:0]                         last_grant,
    output logic [15:0]                             grant_count,
    output logic                                    all_idle
);

    hedios_arb_state_t      state_q, state_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   push_q, push_d;
    hedios_packet_t         pkt_q, pkt_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [15:0]            count_q, count_d;
    logic [3:0]             burst_q, burst_d;

    logic [NUM_REQ-1:0]     hp_req_s, lp_req_s, pick_mask_s;
    logic                   use_hp_s, found_s;
    logic [ID_W-1:0]        win_s;

    assign hp_req_s    = req_valid & HIGH_PRIO_MASK;
    assign lp_req_s    = req_valid & ~HIGH_PRIO_MASK;
    // LP is forced once the HP burst budget is spent while LP work waits.
    assign use_hp_s    = !((lp_req_s != '0) && (burst_q == 4'(MAX_HP_BURST))) && (hp_req_s != '0);
    assign pick_mask_s = use_hp_s ? hp_req_s : lp_req_s;

    hedios_rr_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_picker (
        .mask  (pick_mask_s),
        .ptr   (last_q),
        .found (found_s),
        .index (win_s)
    );

    // Next-state and registered-output computation for the IDLE/PUSH/SETTLE cycle.
    always_comb begin
        state_d = state_q;
        ready_d = '0;
        push_d  = 1'b0;
        pkt_d   = pkt_q;
        last_d  = last_q;
        count_d = count_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (found_s && !tx_full) begin
                    push_d         = 1'b1;
                    ready_d[win_s] = 1'b1;
                    pkt_d.cmd      = req_command[win_s];
                    pkt_d.data     = req_data[win_s];
                    last_d         = win_s;
                    count_d        = count_q + 16'd1;
                    if (use_hp_s && (lp_req_s != '0)) begin
                        burst_d = (burst_q == 4'(MAX_HP_BURST)) ? burst_q : burst_q + 4'd1;
                    end else begin
                        burst_d = 4'd0;
                    end
                    state_d = ARB_PUSH;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_PUSH:   state_d = ARB_SETTLE;
            ARB_SETTLE: state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ready_q <= '0;
            push_q  <= 1'b0;
            pkt_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            count_q <= 16'd0;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            push_q  <= push_d;
            pkt_q   <= pkt_d;
            last_q  <= last_d;
            count_q <= count_d;
            burst_q <= burst_d;
        end
    end

    assign req_ready      = ready_q;
    assign tx_push_packet = push_q;
    assign tx_command     = pkt_q.cmd;
    assign tx_data        = pkt_q.data;
    assign last_grant     = last_q;
    assign grant_count    = count_q;
    assign all_idle       = (state_q == ARB_IDLE) && (req_valid == '0) && tx_empty;

endmodule
